// File: rtl/axim_strided_rd_ctrl_if.sv
// AR/R bus toward the AXI interconnect plus the read-data stream toward the
// vector load unit, bundled so the controller has a single bus port.
interface axim_strided_rd_ctrl_if #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
);
   logic                          m_axi_arvalid;
   logic                          m_axi_arready;
   logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr;
   logic [7:0]                    m_axi_arlen;
   logic                          m_axi_rvalid;
   logic                          m_axi_rready;
   logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata;
   logic                          m_axi_rlast;
   logic                          rd_tvalid;
   logic                          rd_tready;
   logic                          rd_tlast;
   logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata;

   modport master (
      output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
             rd_tvalid, rd_tlast, rd_tdata,
      input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, rd_tready
   );

   modport slave (
      input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
             rd_tvalid, rd_tlast, rd_tdata,
      output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, rd_tready
   );
endinterface

// File: rtl/axim_strided_rd_ctrl.sv
// AXI4 read controller: unit-stride bursts (split at 4 KB) or signed constant-stride
// single beats, bounded outstanding ARs, R data passed through as a stream.
module axim_strided_rd_ctrl #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_MAX_BURST_LEN    = 16,
   parameter int C_MAX_OUTSTANDING  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ctrl_start_i,
   input  logic                          ctrl_mode_i,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_baseaddr_i,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_stride_i,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_elem_cnt_i,
   output logic                          ctrl_busy_o,
   output logic                          ctrl_done_o,
   axim_strided_rd_ctrl_if.master        bus
);
   localparam int AW    = C_M_AXI_ADDR_WIDTH;
   localparam int XW    = C_XFER_SIZE_WIDTH;
   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int OW    = $clog2(C_MAX_OUTSTANDING + 1);
   localparam logic [AW-1:0] ALIGN = ~AW'(BYTES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic            arvalid_q, arvalid_d, mode_q, mode_d;
   logic [AW-1:0]   araddr_q, araddr_d, addr_q, addr_d, stride_q, stride_d;
   logic [7:0]      arlen_q, arlen_d;
   logic [XW-1:0]   rem_q, rem_d, cnt_q, cnt_d, beat_q, beat_d;
   logic [OW-1:0]   outst_q, outst_d;

   logic            busy, rready, ar_hs, r_hs, load;
   logic            gen_mode;
   logic [AW-1:0]   gen_addr, gen_stride, next_addr;
   logic [XW-1:0]   gen_rem, len;
   logic [12:0]     b4k;

   assign busy  = (state_q != IDLE);
   assign rready = busy & bus.rd_tready;
   assign ar_hs = arvalid_q & bus.m_axi_arready;
   assign r_hs  = bus.m_axi_rvalid & rready;

   // Next AR: taken straight from the inputs on the start cycle so arvalid rises one cycle later.
   always_comb begin
      gen_addr   = addr_q;
      gen_rem    = rem_q;
      gen_mode   = mode_q;
      gen_stride = stride_q;
      if (state_q == IDLE) begin
         gen_addr   = ctrl_baseaddr_i & ALIGN;
         gen_rem    = ctrl_elem_cnt_i;
         gen_mode   = ctrl_mode_i;
         gen_stride = ctrl_stride_i & ALIGN;
      end
      b4k = (13'd4096 - {1'b0, gen_addr[11:0]}) >> LSB;
      len = gen_rem;
      if (len > XW'(C_MAX_BURST_LEN)) len = XW'(C_MAX_BURST_LEN);
      if (len > XW'(b4k))             len = XW'(b4k);
      if (gen_mode)                   len = XW'(1);
      next_addr = gen_mode ? gen_addr + gen_stride : gen_addr + (AW'(len) << LSB);
   end

   always_comb begin
      state_d   = state_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      stride_d  = stride_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      outst_d   = outst_q;
      load      = 1'b0;

      if (r_hs)  beat_d = beat_q + XW'(1);
      if (ar_hs) arvalid_d = 1'b0;
      case ({ar_hs, r_hs & bus.m_axi_rlast})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01:   outst_d = outst_q - OW'(1);
         default: outst_d = outst_q;
      endcase

      case (state_q)
         IDLE: if (ctrl_start_i) begin
            mode_d   = ctrl_mode_i;
            stride_d = ctrl_stride_i & ALIGN;
            cnt_d    = ctrl_elem_cnt_i;
            beat_d   = '0;
            if (ctrl_elem_cnt_i == '0) state_d = DONE;
            else begin
               state_d = ISSUE;
               load    = 1'b1;
            end
         end
         ISSUE: begin
            // Refill in the handshake cycle using the post-update outstanding count.
            if ((!arvalid_q || ar_hs) && rem_q != '0 && outst_d < OW'(C_MAX_OUTSTANDING))
               load = 1'b1;
            if (ar_hs && rem_q == '0) state_d = DRAIN;
         end
         DRAIN: if (r_hs && beat_q == cnt_q - XW'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load) begin
         arvalid_d = 1'b1;
         araddr_d  = gen_addr;
         arlen_d   = 8'(len - XW'(1));
         addr_d    = next_addr;
         rem_d     = gen_rem - len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         stride_q  <= '0;
         mode_q    <= 1'b0;
         cnt_q     <= '0;
         beat_q    <= '0;
         outst_q   <= '0;
      end else begin
         state_q   <= state_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         stride_q  <= stride_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         beat_q    <= beat_d;
         outst_q   <= outst_d;
      end
   end

   assign ctrl_busy_o       = busy;
   assign ctrl_done_o       = (state_q == DONE);
   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_araddr  = araddr_q;
   assign bus.m_axi_arlen   = arlen_q;
   assign bus.m_axi_rready  = rready;
   assign bus.rd_tvalid     = busy & bus.m_axi_rvalid;
   assign bus.rd_tdata      = bus.m_axi_rdata;
   assign bus.rd_tlast      = busy & (beat_q == cnt_q - XW'(1));
endmodule
